memory_arbiter: RTL and testbench

- Shares the single external memory port between the instruction-fetch stage and the data-access path (LOAD/STORE).
- Sequences one memory cycle at a time over a variable-latency `mem_ready` handshake.
- Data accesses get fixed priority over fetch, with starvation protection for fetch and a bus timeout.
- Returns read data and a done pulse to the winning requester. Stage 2 consumes `data_rdata` as its `data_in`.

---
 rtl/memory_arbiter_pkg.sv | 26 ++
 rtl/memory_arbiter_timeout_counter.sv | 39 +++
 rtl/memory_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_memory_arbiter.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : memory_arbiter_pkg
//  Description : Shared bus definitions for the memory arbiter slice.
//                t_cycle_width and the CW_* access-width codes, plus the
//                arbiter state encoding t_arb_state.
//  Revision    : 1.0 - initial release
// ============================================================================
package memory_arbiter_pkg;

    // Access width presented on the memory port.
    typedef logic [1:0] t_cycle_width;

    localparam t_cycle_width CW_BYTE = 2'd0;
    localparam t_cycle_width CW_WORD = 2'd1;
    localparam t_cycle_width CW_LONG = 2'd2;

    // Arbiter state; the grant is implied by which BUSY state is active.
    typedef enum logic [1:0] {
        ARB_IDLE       = 2'd0,
        ARB_BUSY_FETCH = 2'd1,
        ARB_BUSY_DATA  = 2'd2
    } t_arb_state;

endpackage : memory_arbiter_pkg
`default_nettype wire

// File: rtl/memory_arbiter_timeout_counter.sv
`default_nettype none
// ============================================================================
//  Module      : bus_timeout_counter
//  Description : Saturating cycle counter used as the bus watchdog.
//                Counts while i_enable is high, saturates at
//                TIMEOUT_CYCLES-1 and flags o_terminal while sitting there.
//  Ports       : clock, reset   - clock / synchronous active-high reset
//                i_clear        - synchronous clear (wins over enable)
//                i_enable       - count this cycle
//                o_terminal     - count == TIMEOUT_CYCLES-1
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_timeout_counter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clock,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_terminal
);

    localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYCLES) < 1) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clock) begin
        if (reset || i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != c_LAST)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_terminal = (r_count == c_LAST);

endmodule : bus_timeout_counter
`default_nettype wire

// File: rtl/memory_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : memory_arbiter
//  Description : Shares one external memory port between instruction fetch
//                and the data (LOAD/STORE) path. One access at a time over a
//                variable-latency mem_ready handshake; data has priority,
//                fetch is protected from starvation, and a watchdog turns a
//                hung access into a bus error.
//  Ports       : clock, reset                         - clock / sync reset
//                fetch_req/address -> fetch_done/rdata - fetch requester
//                data_req/write/address/cycle_width/wdata
//                                  -> data_done/rdata  - data requester
//                bus_error                             - with done on timeout
//                mem_address/cycle_width/wdata/read/write, mem_rdata/ready
//                                                      - memory port
//  Revision    : 1.0 - initial release
// ============================================================================
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         fetch_req,
    input  logic [31:0]  fetch_address,
    output logic         fetch_done,
    output logic [31:0]  fetch_rdata,
    input  logic         data_req,
    input  logic         data_write,
    input  logic [31:0]  data_address,
    input  logic [1:0]   data_cycle_width,
    input  logic [31:0]  data_wdata,
    output logic         data_done,
    output logic [31:0]  data_rdata,
    output logic         bus_error,
    output logic [31:0]  mem_address,
    output logic [1:0]   mem_cycle_width,
    output logic [31:0]  mem_wdata,
    output logic         mem_read,
    output logic         mem_write,
    input  logic [31:0]  mem_rdata,
    input  logic         mem_ready
);

    localparam int unsigned STARVE_W = ($clog2(STARVE_LIMIT + 1) < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [STARVE_W-1:0] c_STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    t_arb_state           r_state,        w_state;
    logic [STARVE_W-1:0]  r_starve,       w_starve;
    logic                 r_fetch_done,   w_fetch_done;
    logic                 r_data_done,    w_data_done;
    logic                 r_bus_error,    w_bus_error;
    logic                 r_mem_read,     w_mem_read;
    logic                 r_mem_write,    w_mem_write;
    logic [31:0]          r_mem_address,  w_mem_address;
    t_cycle_width         r_mem_width,    w_mem_width;
    logic [31:0]          r_mem_wdata,    w_mem_wdata;
    logic [31:0]          r_fetch_rdata,  w_fetch_rdata;
    logic [31:0]          r_data_rdata,   w_data_rdata;

    logic                 w_busy;
    logic                 w_terminal;
    logic                 w_complete;
    logic [31:0]          w_captured;

    assign w_busy     = (r_state != ARB_IDLE);
    // mem_ready takes precedence over an expiring watchdog in the same cycle.
    assign w_complete = w_busy && (mem_ready || w_terminal);
    assign w_captured = mem_ready ? mem_rdata : 32'd0;

    // Counter is held at zero outside an access so every grant starts fresh.
    bus_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clock      (clock),
        .reset      (reset),
        .i_clear    (!w_busy || w_complete),
        .i_enable   (w_busy),
        .o_terminal (w_terminal)
    );

    always_comb begin
        w_state       = r_state;
        w_starve      = r_starve;
        w_fetch_done  = 1'b0;
        w_data_done   = 1'b0;
        w_bus_error   = 1'b0;
        w_mem_read    = r_mem_read;
        w_mem_write   = r_mem_write;
        w_mem_address = r_mem_address;
        w_mem_width   = r_mem_width;
        w_mem_wdata   = r_mem_wdata;
        w_fetch_rdata = r_fetch_rdata;
        w_data_rdata  = r_data_rdata;

        case (r_state)
            ARB_IDLE: begin
                // The cycle showing a done pulse is a dead cycle: the
                // requester has not yet had a chance to drop or renew req.
                if (!(r_fetch_done || r_data_done)) begin
                    if (data_req && !(fetch_req && (r_starve == c_STARVE_MAX))) begin
                        w_state       = ARB_BUSY_DATA;
                        w_mem_address = data_address;
                        w_mem_width   = data_cycle_width;
                        w_mem_wdata   = data_wdata;
                        w_mem_read    = !data_write;
                        w_mem_write   = data_write;
                        if (!fetch_req) begin
                            w_starve = '0;
                        end else if (r_starve != c_STARVE_MAX) begin
                            w_starve = r_starve + STARVE_W'(1);
                        end
                    end else if (fetch_req) begin
                        w_state       = ARB_BUSY_FETCH;
                        w_mem_address = fetch_address;
                        w_mem_width   = CW_LONG;
                        w_mem_read    = 1'b1;
                        w_mem_write   = 1'b0;
                        w_starve      = '0;
                    end
                end
            end

            ARB_BUSY_FETCH, ARB_BUSY_DATA: begin
                if (w_complete) begin
                    w_state     = ARB_IDLE;
                    w_mem_read  = 1'b0;
                    w_mem_write = 1'b0;
                    w_bus_error = !mem_ready;
                    if (r_state == ARB_BUSY_FETCH) begin
                        w_fetch_done  = 1'b1;
                        w_fetch_rdata = w_captured;
                    end else begin
                        w_data_done = 1'b1;
                        // Stores leave the last load result untouched.
                        if (r_mem_read) begin
                            w_data_rdata = w_captured;
                        end
                    end
                end
            end

            default: begin
                w_state     = ARB_IDLE;
                w_mem_read  = 1'b0;
                w_mem_write = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= ARB_IDLE;
            r_starve      <= '0;
            r_fetch_done  <= 1'b0;
            r_data_done   <= 1'b0;
            r_bus_error   <= 1'b0;
            r_mem_read    <= 1'b0;
            r_mem_write   <= 1'b0;
            r_mem_address <= 32'd0;
            r_mem_width   <= CW_LONG;
            r_mem_wdata   <= 32'd0;
            r_fetch_rdata <= 32'd0;
            r_data_rdata  <= 32'd0;
        end else begin
            r_state       <= w_state;
            r_starve      <= w_starve;
            r_fetch_done  <= w_fetch_done;
            r_data_done   <= w_data_done;
            r_bus_error   <= w_bus_error;
            r_mem_read    <= w_mem_read;
            r_mem_write   <= w_mem_write;
            r_mem_address <= w_mem_address;
            r_mem_width   <= w_mem_width;
            r_mem_wdata   <= w_mem_wdata;
            r_fetch_rdata <= w_fetch_rdata;
            r_data_rdata  <= w_data_rdata;
        end
    end

    assign fetch_done      = r_fetch_done;
    assign data_done       = r_data_done;
    assign bus_error       = r_bus_error;
    assign mem_read        = r_mem_read;
    assign mem_write       = r_mem_write;
    assign mem_address     = r_mem_address;
    assign mem_cycle_width = r_mem_width;
    assign mem_wdata       = r_mem_wdata;
    assign fetch_rdata     = r_fetch_rdata;
    assign data_rdata      = r_data_rdata;

endmodule : memory_arbiter
`default_nettype wire

// File: tb/tb_memory_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_memory_arbiter
//  Description : Self-checking bench for memory_arbiter. A transaction-level
//                reference (winner by priority/starvation rule, done time as
//                grant edge + min(latency, timeout)) checks every clock edge.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_memory_arbiter;
    import memory_arbiter_pkg::*;

    localparam int STARVE = 4;
    localparam int TMO    = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        fetch_req = 1'b0;
    logic [31:0] fetch_address = 32'd0;
    logic        fetch_done;
    logic [31:0] fetch_rdata;
    logic        data_req = 1'b0;
    logic        data_write = 1'b0;
    logic [31:0] data_address = 32'd0;
    logic [1:0]  data_cycle_width = CW_LONG;
    logic [31:0] data_wdata = 32'd0;
    logic        data_done;
    logic [31:0] data_rdata;
    logic        bus_error;
    logic [31:0] mem_address;
    logic [1:0]  mem_cycle_width;
    logic [31:0] mem_wdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_rdata = 32'd0;
    logic        mem_ready = 1'b0;

    always #5 clock = ~clock;

    memory_arbiter #(
        .STARVE_LIMIT   (STARVE),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .fetch_req        (fetch_req),
        .fetch_address    (fetch_address),
        .fetch_done       (fetch_done),
        .fetch_rdata      (fetch_rdata),
        .data_req         (data_req),
        .data_write       (data_write),
        .data_address     (data_address),
        .data_cycle_width (data_cycle_width),
        .data_wdata       (data_wdata),
        .data_done        (data_done),
        .data_rdata       (data_rdata),
        .bus_error        (bus_error),
        .mem_address      (mem_address),
        .mem_cycle_width  (mem_cycle_width),
        .mem_wdata        (mem_wdata),
        .mem_read         (mem_read),
        .mem_write        (mem_write),
        .mem_rdata        (mem_rdata),
        .mem_ready        (mem_ready)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- transaction-level reference state ----------------
    int          edge_no   = 0;
    int          busy      = 0;      // 0 none, 1 fetch, 2 data
    int          grant_edge = 0;
    int          lat       = 1;
    int          next_arb  = 0;
    int          starve    = 0;
    logic        cur_read  = 1'b0;
    logic [31:0] exp_addr = 0, exp_wdata = 0;
    logic [1:0]  exp_width = 0;
    logic [31:0] exp_fetch_rdata = 0, exp_data_rdata = 0;
    int          plan_lat  = 1;
    bit          rand_lat  = 0;
    bit          noise     = 0;
    bit          force_rd  = 0;
    logic [31:0] force_val = 0;
    bit          f_seen = 0, d_seen = 0;
    int          last_grant = 0, last_done = 0;
    string       grants = "";

    // One clock edge: drive memory side, predict, clock, check, return at negedge.
    task automatic step();
        int   who  = 0;
        int   fin  = 0;
        bit   tmo  = 0;
        int   dly;
        mem_rdata = force_rd ? force_val : $urandom;
        if (busy != 0) mem_ready = (edge_no == grant_edge + lat);
        else           mem_ready = noise && ($urandom_range(0, 3) == 0);

        if (reset) begin
            busy = 0; starve = 0; next_arb = edge_no + 1;
            exp_fetch_rdata = 0; exp_data_rdata = 0;
        end else if (busy == 0 && edge_no >= next_arb) begin
            if (data_req && !(fetch_req && starve == STARVE)) begin
                who = 2;
                starve = fetch_req ? ((starve < STARVE) ? starve + 1 : STARVE) : 0;
            end else if (fetch_req) begin
                who = 1;
                starve = 0;
            end
            if (who != 0) begin
                busy = who; grant_edge = edge_no; last_grant = edge_no;
                lat = rand_lat ? int'($urandom_range(1, TMO + 2)) : plan_lat;
                cur_read  = (who == 1) || !data_write;
                exp_addr  = (who == 1) ? fetch_address : data_address;
                exp_width = (who == 1) ? CW_LONG : data_cycle_width;
                exp_wdata = (who == 1) ? exp_wdata : data_wdata;
                grants = {grants, (who == 1) ? "F" : "D"};
            end
        end else if (busy != 0) begin
            dly = (lat < TMO) ? lat : TMO;
            if (edge_no == grant_edge + dly) begin
                fin = busy; tmo = (lat > TMO); last_done = edge_no;
                if (fin == 1) exp_fetch_rdata = tmo ? 32'd0 : mem_rdata;
                else if (cur_read) exp_data_rdata = tmo ? 32'd0 : mem_rdata;
            end
        end

        @(posedge clock); #1;

        check("excl_done", {31'd0, fetch_done & data_done}, 32'd0);
        check("excl_strobe", {31'd0, mem_read & mem_write}, 32'd0);
        if (reset) begin
            check("rst_strobes", {30'd0, mem_read, mem_write}, 32'd0);
            check("rst_done", {29'd0, fetch_done, data_done, bus_error}, 32'd0);
            check("rst_addr", mem_address, 32'd0);
            check("rst_wdata", mem_wdata, 32'd0);
            check("rst_width", {30'd0, mem_cycle_width}, {30'd0, CW_LONG});
            check("rst_frdata", fetch_rdata, 32'd0);
            check("rst_drdata", data_rdata, 32'd0);
        end else if (fin != 0) begin
            check("done_fetch", {31'd0, fetch_done}, {31'd0, fin == 1});
            check("done_data", {31'd0, data_done}, {31'd0, fin == 2});
            check("done_buserr", {31'd0, bus_error}, {31'd0, tmo});
            check("done_strobes", {30'd0, mem_read, mem_write}, 32'd0);
            check("done_frdata", fetch_rdata, exp_fetch_rdata);
            check("done_drdata", data_rdata, exp_data_rdata);
        end else if (busy != 0) begin
            check("busy_read", {31'd0, mem_read}, {31'd0, cur_read});
            check("busy_write", {31'd0, mem_write}, {31'd0, !cur_read});
            check("busy_addr", mem_address, exp_addr);
            check("busy_width", {30'd0, mem_cycle_width}, {30'd0, exp_width});
            if (!cur_read) check("busy_wdata", mem_wdata, exp_wdata);
            check("busy_nodone", {29'd0, fetch_done, data_done, bus_error}, 32'd0);
        end else begin
            check("idle_strobes", {30'd0, mem_read, mem_write}, 32'd0);
            check("idle_nodone", {29'd0, fetch_done, data_done, bus_error}, 32'd0);
        end

        if (fin != 0) begin
            busy = 0;
            next_arb = edge_no + 2;
        end
        edge_no++;
        @(negedge clock);
        // Requester contract: req is held until done is seen, then dropped.
        if (fin == 1) begin fetch_req = 1'b0; f_seen = 1; end
        if (fin == 2) begin data_req  = 1'b0; d_seen = 1; end
    endtask

    task automatic run_until_done(input string tag, input bit want_f, input bit want_d);
        for (int i = 0; i < 60 && !((f_seen || !want_f) && (d_seen || !want_d)); i++) step();
        check(tag, {30'd0, f_seen || !want_f, d_seen || !want_d}, 32'd3);
    endtask

    initial begin
        // ---- reset ----
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();

        // ---- single fetch ----
        f_seen = 0; plan_lat = 1; force_rd = 1; force_val = 32'hDEADBEEF;
        fetch_address = 32'h0000_1000; fetch_req = 1'b1;
        run_until_done("single_fetch_wait", 1, 0);
        check("single_fetch_rdata", fetch_rdata, 32'hDEADBEEF);
        check("single_fetch_latency", last_done - last_grant, 32'd1);
        force_rd = 0;
        step();

        // ---- simultaneous requests ----
        f_seen = 0; d_seen = 0; grants = ""; plan_lat = 2;
        fetch_address = 32'h0000_1004; fetch_req = 1'b1;
        data_address = 32'h0000_2003; data_write = 1'b0; data_cycle_width = CW_BYTE; data_req = 1'b1;
        run_until_done("simul_wait", 1, 1);
        check("simul_order", {31'd0, grants == "DF"}, 32'd1);

        // ---- starvation ----
        grants = ""; plan_lat = 1;
        fetch_req = 1'b1; data_req = 1'b1;
        for (int i = 0; i < 60 && grants.len() < 6; i++) begin
            step();
            fetch_req = 1'b1;
            data_req  = 1'b1;
        end
        fetch_req = 1'b0; data_req = 1'b0;
        check("starve_count", grants.len(), 32'd6);
        if (grants.len() >= 6) check("starve_order", {31'd0, grants.substr(0, 5) == "DDDDFD"}, 32'd1);
        for (int i = 0; i < 20 && busy != 0; i++) step();
        step(); step();

        // ---- store ----
        d_seen = 0; plan_lat = 3;
        data_address = 32'h0000_3000; data_wdata = 32'h1234_5678;
        data_cycle_width = CW_WORD; data_write = 1'b1; data_req = 1'b1;
        for (int i = 0; i < 40 && !d_seen; i++) begin
            step();
            if (busy == 2) check("store_wdata", mem_wdata, 32'h1234_5678);
        end
        check("store_done", {31'd0, d_seen}, 32'd1);
        data_write = 1'b0;
        step();

        // ---- timeout ----
        f_seen = 0; plan_lat = 1000;
        fetch_address = 32'h0000_5000; fetch_req = 1'b1;
        run_until_done("timeout_wait", 1, 0);
        check("timeout_latency", last_done - last_grant, TMO);
        check("timeout_rdata", fetch_rdata, 32'd0);
        step(); step();

        // ---- reset mid-access ----
        plan_lat = 1000;
        data_address = 32'h0000_6000; data_cycle_width = CW_LONG; data_write = 1'b0; data_req = 1'b1;
        for (int i = 0; i < 10 && busy != 2; i++) step();
        check("midrst_granted", busy, 32'd2);
        step();
        reset = 1'b1; data_req = 1'b0; d_seen = 0;
        step();
        reset = 1'b0;
        f_seen = 0; plan_lat = 2;
        fetch_address = 32'h0000_7000; fetch_req = 1'b1;
        run_until_done("midrst_fetch", 1, 0);
        check("midrst_no_data_done", {31'd0, d_seen}, 32'd0);

        // ---- randomized traffic ----
        rand_lat = 1; noise = 1;
        for (int i = 0; i < 600; i++) begin
            if (!fetch_req && $urandom_range(0, 2) == 0) begin
                fetch_address = $urandom;
                fetch_req = 1'b1;
            end
            if (!data_req && $urandom_range(0, 2) == 0) begin
                data_address     = $urandom;
                data_wdata       = $urandom;
                data_write       = 1'($urandom_range(0, 1));
                data_cycle_width = 2'($urandom_range(0, 2));
                data_req = 1'b1;
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_memory_arbiter
`default_nettype wire
